// File: rtl/bch_syndrome_stream_pkg.sv
`default_nettype none
// ============================================================================
// bch_pkg : GF(2^M) constants, types and constant-multiply helpers
// Rev 1.0
// ============================================================================
package bch_pkg;

    localparam int M = 4;
    localparam logic [M:0] PRIM_POLY = 5'b1_0011;   // x^4 + x + 1

    typedef logic [M-1:0] gf_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic gf_t mul_alpha(gf_t x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : gf_t'(0));
    endfunction

    function automatic gf_t alpha_pow(int e);
        gf_t v = gf_t'(1);
        int  r = e % ((1 << M) - 1);
        for (int i = 0; i < r; i++) v = mul_alpha(v);
        return v;
    endfunction

    // x * alpha^e as a fixed XOR network: column i of the matrix is alpha^(i+e)
    function automatic gf_t gf_mul_const(gf_t x, int e);
        gf_t r = '0;
        for (int i = 0; i < M; i++) if (x[i]) r ^= alpha_pow(i + e);
        return r;
    endfunction

    function automatic gf_t gf_sq(gf_t x);
        gf_t r = '0;
        for (int i = 0; i < M; i++) if (x[i]) r ^= alpha_pow(2 * i);
        return r;
    endfunction

    function automatic gf_t gf_sq_iter(gf_t x, int k);
        gf_t r = x;
        for (int i = 0; i < k; i++) r = gf_sq(r);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_syndrome_stream_lane.sv
`default_nettype none
// ============================================================================
// bch_synd_lane : Horner accumulator for syndrome S_J, P coefficients per beat
// Rev 1.0
// ============================================================================
module bch_synd_lane
    import bch_pkg::*;
#(
    parameter int J = 1,
    parameter int P = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         first_i,
    input  logic [P-1:0] data_i,
    output logic [M-1:0] acc_d_o
);

    gf_t acc_q;
    gf_t acc_d;
    gf_t w_fold;
    gf_t w_base;

    // First beat of a frame starts from zero so no clearing cycle is needed
    always_comb begin
        w_fold = '0;
        for (int k = 0; k < P; k++) if (data_i[k]) w_fold ^= alpha_pow(J * k);
        w_base = first_i ? '0 : acc_q;
        acc_d  = gf_mul_const(w_base, J * P) ^ w_fold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule
`default_nettype wire

// File: rtl/bch_syndrome_stream.sv
`default_nettype none
// ============================================================================
// bch_syndrome_stream : streaming BCH syndrome generator S1..S2T over GF(2^M)
// Option macro SYND_EVEN_DERIVE_EN: even syndromes derived as squares. Rev 1.0
// ============================================================================
module bch_syndrome_stream #(
    parameter int M = 4,
    parameter int N = 15,
    parameter int T = 2,
    parameter int P = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     in_data,
    output logic             synd_valid,
    input  logic             synd_ready,
    output logic [2*T*M-1:0] synd,
    output logic             synd_zero
);
    import bch_pkg::*;

    localparam int BEATS = N / P;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef SYND_EVEN_DERIVE_EN
    localparam bit EVEN_DERIVE = 1'b1;
`else
    localparam bit EVEN_DERIVE = 1'b0;
`endif

    if (N % P != 0) begin : g_chk_np
        $error("N must be a multiple of P");
    end
    if (N > (1 << M) - 1) begin : g_chk_n
        $error("N exceeds 2^M-1");
    end
    if (M != bch_pkg::M) begin : g_chk_m
        $error("M must match the package field degree");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             synd_valid_q;
    logic             synd_zero_q;
    logic [2*T-1:0]   w_nz;
    logic             w_accept;
    logic             w_first;
    logic             w_last;

    assign w_accept = (state_q == ACCUM) && in_valid && in_ready_q && !clear;
    assign w_first  = (cnt_q == '0);
    assign w_last   = w_accept && (cnt_q == CNT_W'(BEATS - 1));

    for (genvar j = 1; j <= 2 * T; j++) begin : g_lane
        if (EVEN_DERIVE && (j % 2 == 0)) begin : g_derive
            // S_(o*2^k) = S_o squared k times, o odd
            localparam int K    = $clog2(j & -j);
            localparam int BASE = j >> K;
            assign synd[j*M-1 -: M] = gf_sq_iter(g_lane[BASE].g_acc.synd_q, K);
            assign w_nz[j-1]        = 1'b0;
        end else begin : g_acc
            gf_t w_nxt;
            gf_t synd_q;

            bch_synd_lane #(.J(j), .P(P)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load_i  (w_accept),
                .first_i (w_first),
                .data_i  (in_data),
                .acc_d_o (w_nxt)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    synd_q <= '0;
                end else if (w_last) begin
                    synd_q <= w_nxt;
                end
            end

            assign synd[j*M-1 -: M] = synd_q;
            assign w_nz[j-1]        = |w_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            synd_valid_q <= 1'b0;
            synd_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (clear) begin
                        cnt_q <= '0;
                    end else if (w_last) begin
                        cnt_q        <= '0;
                        state_q      <= HOLD;
                        in_ready_q   <= 1'b0;
                        synd_valid_q <= 1'b1;
                        synd_zero_q  <= ~|w_nz;
                    end else if (w_accept) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (clear || synd_ready) begin
                        state_q      <= ACCUM;
                        in_ready_q   <= 1'b1;
                        synd_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign synd_valid = synd_valid_q;
    assign synd_zero  = synd_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_stream.sv
`default_nettype none
// ============================================================================
// tb_bch_syndrome_stream : directed self-checking bench, M=4 N=15 T=2 P=5
// Rev 1.0
// ============================================================================
module tb_bch_syndrome_stream;

    localparam int M = 4;
    localparam int N = 15;
    localparam int T = 2;
    localparam int P = 5;

    localparam logic [14:0] CW_ZERO = 15'h0000;
    localparam logic [14:0] CW_BIT0 = 15'h0001;
    localparam logic [14:0] CW_BIT1 = 15'h0002;
    localparam logic [14:0] CW_B14  = 15'h4000;
    localparam logic [14:0] CW_GEN  = 15'h01D1;
    // {S4,S3,S2,S1}
    localparam logic [15:0] S_BIT0 = 16'h1111;
    localparam logic [15:0] S_BIT1 = 16'h3842;
    localparam logic [15:0] S_B14  = 16'hEFD9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [P-1:0]     in_data = '0;
    logic             synd_valid;
    logic             synd_ready = 1'b0;
    logic [2*T*M-1:0] synd;
    logic             synd_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bch_syndrome_stream #(.M(M), .N(N), .T(T), .P(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .synd_valid (synd_valid),
        .synd_ready (synd_ready),
        .synd       (synd),
        .synd_zero  (synd_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [14:0] cw, input int nb, output int cycles);
        int guard;
        cycles = 0;
        for (int b = 0; b < nb; b++) begin
            in_valid = 1'b1;
            in_data  = cw[14-5*b -: 5];
            guard    = 0;
            while (!in_ready && guard < 20) begin
                tick();
                cycles++;
                guard++;
            end
            if (!in_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout beat=%0d in_ready=%b required 1", b, in_ready);
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_tests++; if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_synd_valid got %b want 0", synd_valid); end
        n_tests++; if (synd !== 16'h0)      begin n_fail++; $display("FAIL rst_synd got %h want 0000", synd); end
        n_tests++; if (synd_zero !== 1'b0)  begin n_fail++; $display("FAIL rst_synd_zero got %b want 0", synd_zero); end
        rst = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_zero_frame;
        int c;
        synd_ready = 1'b1;
        send_beats(CW_ZERO, 3, c);
        n_tests++; if (c != 3)              begin n_fail++; $display("FAIL zero_accept_cycles got %0d want 3", c); end
        n_tests++; if (synd_valid !== 1'b1) begin n_fail++; $display("FAIL zero_latency synd_valid got %b want 1", synd_valid); end
        n_tests++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL zero_hold_in_ready got %b want 0", in_ready); end
        n_tests++; if (synd !== 16'h0)      begin n_fail++; $display("FAIL zero_synd got %h want 0000", synd); end
        n_tests++; if (synd_zero !== 1'b1)  begin n_fail++; $display("FAIL zero_flag got %b want 1", synd_zero); end
        tick();
        n_tests++; if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_release synd_valid got %b want 0", synd_valid); end
    endtask

    task automatic test_single(input logic [14:0] cw, input logic [15:0] exp, input int tag);
        int c;
        synd_ready = 1'b1;
        send_beats(cw, 3, c);
        n_tests++; if (synd_valid !== 1'b1) begin n_fail++; $display("FAIL single%0d_valid got %b want 1", tag, synd_valid); end
        n_tests++; if (synd !== exp)        begin n_fail++; $display("FAIL single%0d_synd got %h want %h", tag, synd, exp); end
        n_tests++; if (synd_zero !== 1'b0)  begin n_fail++; $display("FAIL single%0d_flag got %b want 0", tag, synd_zero); end
        tick();
    endtask

    task automatic test_back_to_back;
        int c;
        int t1;
        synd_ready = 1'b1;
        send_beats(CW_GEN, 3, c);
        t1 = cyc;
        n_tests++; if (synd !== 16'h0 || synd_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_frame1 got %h/%b want 0000/1", synd, synd_zero); end
        send_beats(CW_GEN, 3, c);
        n_tests++; if (cyc - t1 != 4)       begin n_fail++; $display("FAIL b2b_period got %0d want 4", cyc - t1); end
        n_tests++; if (synd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", synd_valid); end
        n_tests++; if (synd !== 16'h0 || synd_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_frame2 got %h/%b want 0000/1", synd, synd_zero); end
        tick();
    endtask

    task automatic test_backpressure;
        int c;
        synd_ready = 1'b0;
        send_beats(CW_BIT1, 3, c);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 5'h1F;
            tick();
            n_tests++;
            if (in_ready !== 1'b0 || synd_valid !== 1'b1 || synd !== S_BIT1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got rdy=%b vld=%b synd=%h want 0/1/%h", i, in_ready, synd_valid, synd, S_BIT1);
            end
        end
        in_valid   = 1'b0;
        synd_ready = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1 || synd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, synd_valid); end
        send_beats(CW_BIT0, 3, c);
        n_tests++; if (c != 3)              begin n_fail++; $display("FAIL bp_next_accept got %0d want 3", c); end
        n_tests++; if (synd !== S_BIT0)     begin n_fail++; $display("FAIL bp_next_synd got %h want %h", synd, S_BIT0); end
        tick();
    endtask

    task automatic test_clear;
        int c;
        synd_ready = 1'b1;
        send_beats(CW_B14, 2, c);
        in_valid = 1'b1;
        in_data  = 5'h1F;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (synd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_drop_beat synd_valid got %b want 0", synd_valid); end
        send_beats(CW_BIT1, 3, c);
        n_tests++; if (synd !== S_BIT1)     begin n_fail++; $display("FAIL clear_next_synd got %h want %h", synd, S_BIT1); end
        tick();
        synd_ready = 1'b0;
        send_beats(CW_BIT0, 3, c);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++; if (synd_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_hold got vld=%b rdy=%b want 0/1", synd_valid, in_ready); end
    endtask

    task automatic test_rst_abort;
        int c;
        synd_ready = 1'b0;
        send_beats(CW_BIT1, 3, c);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || synd_valid !== 1'b0 || synd !== 16'h0 || synd_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold got rdy=%b vld=%b synd=%h zero=%b want 0/0/0000/0", in_ready, synd_valid, synd, synd_zero);
        end
        tick();
        rst = 1'b0;
        tick();
        send_beats(CW_B14, 1, c);
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        synd_ready = 1'b1;
        send_beats(CW_BIT0, 3, c);
        n_tests++; if (synd_valid !== 1'b1 || synd !== S_BIT0) begin n_fail++; $display("FAIL rst_next_frame got vld=%b synd=%h want 1/%h", synd_valid, synd, S_BIT0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single(CW_BIT0, S_BIT0, 0);
        test_single(CW_BIT1, S_BIT1, 1);
        test_single(CW_B14,  S_B14,  14);
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_rst_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
